// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the pipeline hazard/forwarding control
package pipe_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_ALU     = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b10;

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } shadow_t;

  // $0 is hardwired zero, so a write to it never produces a value worth forwarding
  function automatic logic writes_reg(shadow_t e, logic [REG_AW-1:0] src);
    return e.valid && e.reg_write && (e.rd == src) && (src != '0);
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// rtl/hazard_forward_ctrl_if.sv - ID-stage decode fields in, forwarding selects and stall controls out
interface hazard_forward_ctrl_if;
  import pipe_pkg::*;

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic              id_use_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush_id;
  logic              dmem_busy;
  logic [1:0]        fwd_sel_a;
  logic [1:0]        fwd_sel_b;
  logic              pc_hold;
  logic              idex_bubble;
  logic              freeze;
  shadow_t           wb_entry;

  modport master (
    output id_valid, id_rs, id_use_rs, id_rt, id_use_rt, id_rd,
           id_reg_write, id_mem_read, flush_id, dmem_busy,
    input  fwd_sel_a, fwd_sel_b, pc_hold, idex_bubble, freeze, wb_entry
  );

  modport slave (
    input  id_valid, id_rs, id_use_rs, id_rt, id_use_rt, id_rd,
           id_reg_write, id_mem_read, flush_id, dmem_busy,
    output fwd_sel_a, fwd_sel_b, pc_hold, idex_bubble, freeze, wb_entry
  );

endinterface

// File: rtl/hazard_forward_ctrl_fwd_src_cmp.sv
// rtl/hazard_forward_ctrl_fwd_src_cmp.sv - one source index against EX/MEM shadow entries
module fwd_src_cmp
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              use_src,
  input  shadow_t           ex_e,
  input  shadow_t           mem_e,
  output logic [1:0]        sel
);

  // The EX entry is checked first: the nearer producer holds the newest value
  always_comb begin
    sel = FWD_REGFILE;
    if (use_src) begin
      if (writes_reg(ex_e, src))       sel = FWD_ALU;
      else if (writes_reg(mem_e, src)) sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - operand forwarding selects, load-use bubbles and memory-wait freeze
module hazard_forward_ctrl
  import pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_forward_ctrl_if.slave hz
);

  shadow_t    ex_q, mem_q, wb_q, id_e;
  state_e     state_q;
  logic [1:0] sel_a, sel_b, fwd_a_q, fwd_b_q;
  logic       load_use, frozen, issue_bubble, id_live;

  fwd_src_cmp u_cmp_a (.src(hz.id_rs), .use_src(hz.id_use_rs), .ex_e(ex_q), .mem_e(mem_q), .sel(sel_a));
  fwd_src_cmp u_cmp_b (.src(hz.id_rt), .use_src(hz.id_use_rt), .ex_e(ex_q), .mem_e(mem_q), .sel(sel_b));

  // A squashed instruction never stalls, so flush_id masks the load-use detect
  always_comb begin
    load_use = hz.id_valid && !hz.flush_id && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
               ((hz.id_use_rs && (hz.id_rs == ex_q.rd)) || (hz.id_use_rt && (hz.id_rt == ex_q.rd)));
    frozen       = hz.dmem_busy && rst_n;
    issue_bubble = load_use && !frozen;
    id_live      = hz.id_valid && !hz.flush_id && !issue_bubble;
    id_e         = '0;
    if (id_live) begin
      id_e.valid     = 1'b1;
      id_e.rd        = hz.id_rd;
      id_e.reg_write = hz.id_reg_write;
      id_e.mem_read  = hz.id_mem_read;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_REGFILE;
      fwd_b_q <= FWD_REGFILE;
      state_q <= RUN;
    end else if (frozen) begin
      state_q <= MEM_WAIT;
    end else begin
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      ex_q    <= id_e;
      fwd_a_q <= id_live ? sel_a : FWD_REGFILE;
      fwd_b_q <= id_live ? sel_b : FWD_REGFILE;
      // The bubble just issued clears EX, so LOAD_STALL always falls back to RUN
      unique case (state_q)
        RUN, MEM_WAIT: state_q <= load_use ? LOAD_STALL : RUN;
        LOAD_STALL:    state_q <= RUN;
        default:       state_q <= RUN;
      endcase
    end
  end

  assign hz.fwd_sel_a   = fwd_a_q;
  assign hz.fwd_sel_b   = fwd_b_q;
  assign hz.freeze      = frozen;
  assign hz.pc_hold     = frozen || load_use;
  assign hz.idex_bubble = issue_bubble;
  assign hz.wb_entry    = wb_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - directed self-checking bench for hazard_forward_ctrl
module tb_hazard_forward_ctrl;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  hazard_forward_ctrl_if hz ();

  hazard_forward_ctrl dut (.clk(clk), .rst_n(rst_n), .hz(hz));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                       input logic [4:0] rd, input logic rw, input logic mr);
    hz.id_valid = 1'b1; hz.id_rs = rs; hz.id_use_rs = urs; hz.id_rt = rt; hz.id_use_rt = urt;
    hz.id_rd = rd; hz.id_reg_write = rw; hz.id_mem_read = mr;
  endtask

  task automatic nop();
    hz.id_valid = 1'b0; hz.id_rs = '0; hz.id_use_rs = 1'b0; hz.id_rt = '0; hz.id_use_rt = 1'b0;
    hz.id_rd = '0; hz.id_reg_write = 1'b0; hz.id_mem_read = 1'b0;
  endtask

  task automatic chk_sel(input string tag, input logic [1:0] a, input logic [1:0] b);
    chk({tag, "_sel_a"}, {6'd0, hz.fwd_sel_a}, {6'd0, a});
    chk({tag, "_sel_b"}, {6'd0, hz.fwd_sel_b}, {6'd0, b});
  endtask

  task automatic chk_ctl(input string tag, input logic ph, input logic bub, input logic frz);
    #1;
    chk({tag, "_ctl"}, {5'd0, hz.pc_hold, hz.idex_bubble, hz.freeze}, {5'd0, ph, bub, frz});
  endtask

  initial begin
    rst_n = 1'b0;
    nop();
    hz.flush_id = 1'b0;
    hz.dmem_busy = 1'b0;
    #2;
    chk_sel("reset", 2'b00, 2'b00);
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_wb", hz.wb_entry, 8'h00);
    cyc();
    rst_n = 1'b1;

    // 1: add $3,$1,$2 ; sub $4,$3,$5
    instr(5'd1, 1, 5'd2, 1, 5'd3, 1, 0); cyc();
    chk_sel("t1_add", 2'b00, 2'b00);
    instr(5'd3, 1, 5'd5, 1, 5'd4, 1, 0);
    chk_ctl("t1_sub", 1'b0, 1'b0, 1'b0);
    cyc();
    chk_sel("t1_sub", 2'b01, 2'b00);
    nop(); cyc();
    chk_sel("t1_nop", 2'b00, 2'b00);
    chk("t1_wb_add", hz.wb_entry, 8'h8E);

    // 2: add $3 ; nop ; or $6,$7,$3  then add $3 ; add $3 ; use $3
    instr(5'd1, 1, 5'd2, 1, 5'd3, 1, 0); cyc();
    nop(); cyc();
    instr(5'd7, 1, 5'd3, 1, 5'd6, 1, 0); cyc();
    chk_sel("t2_or", 2'b00, 2'b10);
    instr(5'd1, 1, 5'd2, 1, 5'd3, 1, 0); cyc();
    instr(5'd1, 1, 5'd2, 1, 5'd3, 1, 0); cyc();
    instr(5'd3, 1, 5'd3, 0, 5'd11, 1, 0); cyc();
    chk_sel("t2_nearest", 2'b01, 2'b00);

    // 3: lw $8,0($1) ; add $9,$8,$8
    instr(5'd1, 1, 5'd0, 0, 5'd8, 1, 1); cyc();
    instr(5'd8, 1, 5'd8, 1, 5'd9, 1, 0);
    chk_ctl("t3_stall", 1'b1, 1'b1, 1'b0);
    cyc();
    chk_sel("t3_bubble", 2'b00, 2'b00);
    chk_ctl("t3_after", 1'b0, 1'b0, 1'b0);
    cyc();
    chk_sel("t3_add", 2'b10, 2'b10);

    // 4: writes to $0
    instr(5'd1, 1, 5'd2, 1, 5'd0, 1, 0); cyc();
    instr(5'd0, 1, 5'd0, 1, 5'd10, 1, 0); cyc();
    chk_sel("t4_add0", 2'b00, 2'b00);
    instr(5'd1, 1, 5'd0, 0, 5'd0, 1, 1); cyc();
    instr(5'd0, 1, 5'd0, 1, 5'd10, 1, 0);
    chk_ctl("t4_lw0", 1'b0, 1'b0, 1'b0);
    cyc();
    chk_sel("t4_use0", 2'b00, 2'b00);

    // 5: lw $8,0($10) ; add $9,$8,$8 with dmem_busy for 3 cycles at the hazard
    instr(5'd10, 1, 5'd0, 0, 5'd8, 1, 1); cyc();
    chk_sel("t5_lw", 2'b01, 2'b00);
    instr(5'd8, 1, 5'd8, 1, 5'd9, 1, 0);
    hz.dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_ctl("t5_frozen", 1'b1, 1'b0, 1'b1);
      cyc();
      chk_sel("t5_held", 2'b01, 2'b00);
    end
    hz.dmem_busy = 1'b0;
    chk_ctl("t5_release", 1'b1, 1'b1, 1'b0);
    cyc();
    chk_sel("t5_bubble", 2'b00, 2'b00);
    chk_ctl("t5_once", 1'b0, 1'b0, 1'b0);
    cyc();
    chk_sel("t5_add", 2'b10, 2'b10);

    // 6: flush_id with a load-use hazard, then reset mid-MEM_WAIT
    instr(5'd1, 1, 5'd0, 0, 5'd8, 1, 1); cyc();
    instr(5'd8, 1, 5'd8, 1, 5'd9, 1, 0);
    hz.flush_id = 1'b1;
    chk_ctl("t6_flush", 1'b0, 1'b0, 1'b0);
    cyc();
    chk_sel("t6_flush", 2'b00, 2'b00);
    hz.flush_id = 1'b0;
    instr(5'd1, 1, 5'd2, 1, 5'd3, 1, 0); cyc();
    instr(5'd3, 1, 5'd5, 1, 5'd4, 1, 0); cyc();
    chk_sel("t6_pre", 2'b01, 2'b00);
    nop();
    hz.dmem_busy = 1'b1;
    cyc(); cyc();
    chk_ctl("t6_wait", 1'b1, 1'b0, 1'b1);
    chk_sel("t6_wait", 2'b01, 2'b00);
    #1;
    rst_n = 1'b0;
    chk_ctl("t6_rst", 1'b0, 1'b0, 1'b0);
    chk_sel("t6_rst", 2'b00, 2'b00);
    cyc();
    rst_n = 1'b1;
    hz.dmem_busy = 1'b0;
    instr(5'd3, 1, 5'd5, 1, 5'd4, 1, 0); cyc();
    chk_sel("t6_forgot", 2'b00, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
